// File: rtl/sha1_msg_padder.sv
// Writes a byte stream into word memory as a SHA-1 padded message (0x80, zeros, 64-bit bit length).
// Bytes pack big-endian into 32-bit words; reports block count and done/error flags.
module sha1_msg_padder #(
  parameter int ADDR_W     = 8,
  parameter int MAX_BLOCKS = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              empty_msg,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W-1:0] num_blocks,
  output logic              done,
  output logic              error
);

  localparam int CNT_W   = ADDR_W + 2;
  localparam int MAX_MSG = MAX_BLOCKS * 64 - 9;

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_PAD80, S_ZERO, S_LEN, S_DONE, S_ERROR
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  byte_cnt_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [1:0]        lane_q;
  logic [23:0]       hold_q;
  logic [2:0]        len_idx_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [ADDR_W-1:0] num_blocks_q;
  logic              done_q;
  logic              error_q;

  logic              emit_vld;
  logic [7:0]        emit_byte;
  logic              accept;
  logic [5:0]        pos_mod;
  logic [63:0]       bit_len;

  assign in_ready = (state_q == S_DATA) && (byte_cnt_q < CNT_W'(MAX_MSG));
  assign accept   = in_valid && in_ready;
  // Byte position within the current 64-byte block, derived from word count and lane.
  assign pos_mod  = {word_cnt_q[3:0], lane_q};
  assign bit_len  = 64'({byte_cnt_q, 3'b000});

  always_comb begin
    emit_vld  = 1'b0;
    emit_byte = 8'h00;
    case (state_q)
      S_DATA: begin
        emit_vld  = accept;
        emit_byte = in_data;
      end
      S_PAD80: begin
        emit_vld  = 1'b1;
        emit_byte = 8'h80;
      end
      S_ZERO: begin
        emit_vld  = (pos_mod != 6'd56);
        emit_byte = 8'h00;
      end
      S_LEN: begin
        emit_vld  = 1'b1;
        emit_byte = bit_len[{~len_idx_q, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      word_cnt_q   <= '0;
      lane_q       <= '0;
      hold_q       <= '0;
      len_idx_q    <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      num_blocks_q <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      if (emit_vld) begin
        if (lane_q == 2'd3) begin
          mem_we_q    <= 1'b1;
          mem_addr_q  <= word_cnt_q[ADDR_W-1:0];
          mem_wdata_q <= {hold_q, emit_byte};
          word_cnt_q  <= word_cnt_q + 1'b1;
        end else begin
          hold_q <= {hold_q[15:0], emit_byte};
        end
        lane_q <= lane_q + 2'd1;
      end

      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q      <= empty_msg ? S_PAD80 : S_DATA;
            byte_cnt_q   <= '0;
            word_cnt_q   <= '0;
            lane_q       <= '0;
            hold_q       <= '0;
            len_idx_q    <= '0;
            num_blocks_q <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
          end else if (state_q == S_DONE) begin
            // Entered after the last write was issued, so word_cnt is final here.
            done_q       <= 1'b1;
            num_blocks_q <= ADDR_W'(word_cnt_q >> 4);
          end
        end
        S_DATA: begin
          if (accept) begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (in_last) state_q <= S_PAD80;
          end else if (in_valid) begin
            state_q <= S_ERROR;
            error_q <= 1'b1;
          end
        end
        S_PAD80: state_q <= S_ZERO;
        S_ZERO: begin
          if (pos_mod == 6'd56 || pos_mod == 6'd55) state_q <= S_LEN;
        end
        S_LEN: begin
          len_idx_q <= len_idx_q + 3'd1;
          if (len_idx_q == 3'd7) state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign num_blocks = num_blocks_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Scoreboard bench for sha1_msg_padder: reference padding model queues expected word writes,
// a negedge monitor pops and compares each mem_we; directed and random messages.
module tb_sha1_msg_padder;
  localparam int ADDR_W     = 8;
  localparam int MAX_BLOCKS = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              empty_msg = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W-1:0] num_blocks;
  logic              done;
  logic              error;

  sha1_msg_padder #(.ADDR_W(ADDR_W), .MAX_BLOCKS(MAX_BLOCKS)) dut (
    .clk(clk), .reset(reset), .start(start), .empty_msg(empty_msg),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .num_blocks(num_blocks), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] msg_q[$];
  int         total = 0;
  int         bad = 0;
  int         exp_blocks = 0;
  time        acc_t = 0;
  time        done_t = 0;
  time        lat_plain = 0;
  wr_t        mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, expv);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL stray_write: got addr %0h data %0h want no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(mon_e.addr));
        chk("wr_data", 64'(mem_wdata), 64'(mon_e.data));
      end
    end
  end

  // Reference: pad the message as a flat byte list, then cut it into big-endian words.
  task automatic model_push();
    logic [7:0]  p[$];
    logic [63:0] bl;
    p = msg_q;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    bl = 64'(msg_q.size()) * 64'd8;
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    for (int w = 0; w < p.size() / 4; w++)
      exp_q.push_back(wr_t'{addr: ADDR_W'(w), data: {p[4*w], p[4*w+1], p[4*w+2], p[4*w+3]}});
    exp_blocks = p.size() / 64;
  endtask

  task automatic pulse_start(input logic emp);
    start = 1'b1;
    empty_msg = emp;
    @(posedge clk); #1;
    start = 1'b0;
    empty_msg = 1'b0;
  endtask

  task automatic send_msg(input int gap_min, input int gap_max, input bit no_last, input bit pulse_mid);
    @(posedge clk); #1;
    pulse_start(msg_q.size() == 0 ? 1'b1 : 1'b0);
    for (int i = 0; i < msg_q.size(); i++) begin
      int g;
      int n;
      g = int'($urandom_range(gap_max, gap_min));
      repeat (g) begin @(posedge clk); #1; end
      if (pulse_mid && i == 1) pulse_start(1'b1);
      in_valid = 1'b1;
      in_data  = msg_q[i];
      in_last  = (!no_last && i == msg_q.size() - 1);
      n = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) begin
        total++; bad++;
        $display("FAIL handshake_timeout: got in_ready=0 for 50 cycles want 1");
      end
      @(posedge clk);
      acc_t = $time;
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (done !== 1'b1 && error !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    if (n >= 600) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done in 600 cycles want done", nm);
    end
    done_t = $time;
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_error"}, 64'(error), 64'd0);
    chk({nm, "_blocks"}, 64'(num_blocks), 64'(exp_blocks));
    chk({nm, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string nm);
    @(negedge clk);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_error"}, 64'(error), 64'd0);
    chk({nm, "_we"}, 64'(mem_we), 64'd0);
    chk({nm, "_rdy"}, 64'(in_ready), 64'd0);
    chk({nm, "_blocks"}, 64'(num_blocks), 64'd0);
    chk({nm, "_addr"}, 64'(mem_addr), 64'd0);
    chk({nm, "_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  task automatic load_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // "abc", no gaps
    load_abc();
    model_push();
    send_msg(0, 0, 1'b0, 1'b0);
    wait_done("abc");
    lat_plain = done_t - acc_t;
    repeat (5) @(negedge clk);
    chk("done_held", 64'(done), 64'd1);

    // empty message
    msg_q.delete();
    model_push();
    send_msg(0, 0, 1'b0, 1'b0);
    wait_done("empty");

    // 55 and 56 byte boundaries, and the largest message that fits
    foreach (msg_q[i]) ;
    for (int len = 55; len <= 56; len++) begin
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'(i));
      model_push();
      send_msg(0, 0, 1'b0, 1'b0);
      wait_done(len == 55 ? "len55" : "len56");
    end
    msg_q.delete();
    for (int i = 0; i < 247; i++) msg_q.push_back(8'($urandom));
    model_push();
    send_msg(0, 0, 1'b0, 1'b0);
    wait_done("len247");

    // overflow: 247 bytes without last, then a 248th byte
    msg_q.delete();
    for (int i = 0; i < 247; i++) msg_q.push_back(8'($urandom));
    for (int w = 0; w < 61; w++)
      exp_q.push_back(wr_t'{addr: ADDR_W'(w), data: {msg_q[4*w], msg_q[4*w+1], msg_q[4*w+2], msg_q[4*w+3]}});
    send_msg(0, 0, 1'b1, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    @(negedge clk);
    chk("ovf_rdy", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("ovf_error", 64'(error), 64'd1);
    chk("ovf_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("ovf_error_held", 64'(error), 64'd1);
    chk("ovf_drain", 64'(exp_q.size()), 64'd0);

    // "abc" with 3-cycle gaps: same image, latency after the last byte unchanged
    load_abc();
    model_push();
    send_msg(3, 3, 1'b0, 1'b0);
    wait_done("abc_gap");
    chk("gap_latency", 64'(done_t - acc_t), 64'(lat_plain));

    // reset mid-message, then "abc" with start pulses in DATA and ZERO
    msg_q.delete();
    msg_q.push_back(8'h11);
    msg_q.push_back(8'h22);
    send_msg(0, 0, 1'b1, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    reset = 1'b1;
    load_abc();
    model_push();
    send_msg(0, 1, 1'b0, 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    pulse_start(1'b1);
    wait_done("abc_restart");

    // random messages with random gaps
    for (int k = 0; k < 8; k++) begin
      int len;
      len = int'($urandom_range(120, 0));
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
      model_push();
      send_msg(0, int'($urandom_range(2, 0)), 1'b0, 1'b0);
      wait_done("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
